pll_loop_filter: RTL and testbench

//  PI loop filter for the phase-locking path. Consumes the conditioned phase

---
 rtl/pll_loop_filter_if.sv | 25 ++
 rtl/pll_loop_filter.sv | 95 +++++++++
 tb/tb_pll_loop_filter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pll_loop_filter_if.sv
// Phase-error in / control-word out bundle between the phase detector, loop filter and NCO.
interface pll_loop_filter_if #(
  parameter int unsigned w  = 17,
  parameter int unsigned ow = 18
) ();
  logic signed [w-1:0]  ang_in;
  logic                 strobe_in;
  logic [3:0]           kp_sh;
  logic [3:0]           ki_sh;
  logic                 hold;
  logic                 int_clear;
  logic signed [ow-1:0] ctl_out;
  logic                 strobe_out;
  logic                 int_sat;

  modport master (
    output ang_in, strobe_in, kp_sh, ki_sh, hold, int_clear,
    input  ctl_out, strobe_out, int_sat
  );

  modport slave (
    input  ang_in, strobe_in, kp_sh, ki_sh, hold, int_clear,
    output ctl_out, strobe_out, int_sat
  );
endinterface

// File: rtl/pll_loop_filter.sv
// PI loop filter: shift-gain proportional path plus saturating integrator, two-stage pipeline.
module pll_loop_filter #(
  parameter int unsigned w  = 17,
  parameter int unsigned iw = 24,
  parameter int unsigned ow = 18
) (
  input logic              clk,
  input logic              reset,
  pll_loop_filter_if.slave bus
);

  localparam logic signed [iw-1:0] max_val = {1'b0, {(iw-1){1'b1}}};
  localparam logic signed [iw-1:0] min_val = {1'b1, {(iw-1){1'b0}}};

  logic signed [iw-1:0] x, prop, inc;
  logic signed [iw:0]   acc_sum, out_sum;
  logic                 acc_ovf, out_ovf;
  logic signed [iw-1:0] acc_clamped, out_clamped;

  logic signed [iw-1:0] acc_q, acc_d, prop_q;
  logic                 sat1_q, sat1_d, vld1_q;

  logic signed [ow-1:0] ctl_q;
  logic                 int_sat_q, strobe_out_q;

  // Align the error to the integrator MSB, apply gains, form both clamped sums.
  always_comb begin
    x       = {bus.ang_in, {(iw-w){1'b0}}};
    prop    = x >>> bus.kp_sh;
    inc     = x >>> bus.ki_sh;
    acc_sum = {acc_q[iw-1], acc_q} + {inc[iw-1], inc};
    acc_ovf = acc_sum[iw] ^ acc_sum[iw-1];
    if (acc_ovf) acc_clamped = acc_sum[iw] ? min_val : max_val;
    else         acc_clamped = acc_sum[iw-1:0];
    out_sum = {acc_q[iw-1], acc_q} + {prop_q[iw-1], prop_q};
    out_ovf = out_sum[iw] ^ out_sum[iw-1];
    if (out_ovf) out_clamped = out_sum[iw] ? min_val : max_val;
    else         out_clamped = out_sum[iw-1:0];
  end

  // Integrator next state: clear wins over hold and is honoured even without a strobe.
  always_comb begin
    acc_d  = acc_q;
    sat1_d = 1'b0;
    if (bus.int_clear) begin
      acc_d = '0;
    end else if (bus.strobe_in && !bus.hold) begin
      acc_d  = acc_clamped;
      sat1_d = acc_ovf;
    end
  end

  // Stage 1: integrator, registered proportional term and valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      prop_q <= '0;
      sat1_q <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      vld1_q <= bus.strobe_in;
      if (bus.strobe_in) begin
        prop_q <= prop;
        sat1_q <= sat1_d;
      end
    end
  end

  // Stage 2: output word and saturation flag, held between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctl_q        <= '0;
      int_sat_q    <= 1'b0;
      strobe_out_q <= 1'b0;
    end else begin
      strobe_out_q <= vld1_q;
      if (vld1_q) begin
        ctl_q     <= out_clamped[iw-1 -: ow];
        int_sat_q <= sat1_q | out_ovf;
      end
    end
  end

  // Fractional bits below the output word are dropped by design.
  if (ow < iw) begin : g_trunc
    logic unused_frac;
    assign unused_frac = ^out_clamped[iw-ow-1:0];
  end

  assign bus.ctl_out    = ctl_q;
  assign bus.int_sat    = int_sat_q;
  assign bus.strobe_out = strobe_out_q;

endmodule

// File: tb/tb_pll_loop_filter.sv
// Directed bench for pll_loop_filter with hand-computed control words (w=17, iw=24, ow=18).
module tb_pll_loop_filter;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   exp_ctl[8];
  logic exp_sat[8];

  pll_loop_filter_if #(.w(17), .ow(18)) bus ();

  pll_loop_filter #(.w(17), .iw(24), .ow(18)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.strobe_in = 1'b0;
    bus.hold      = 1'b0;
    bus.int_clear = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issue n back-to-back strobes; output k must appear exactly two cycles after strobe k.
  task automatic run_burst(input string tag, input int n, input logic [16:0] ang,
                           input logic [3:0] kp, input logic [3:0] ki,
                           input logic hld, input logic clr);
    for (int i = 0; i < n + 2; i++) begin
      if (i >= 2) begin
        check({tag, "_stb"}, {31'b0, bus.strobe_out}, 32'd1);
        check({tag, "_ctl"}, {14'b0, bus.ctl_out}, exp_ctl[i-2]);
        check({tag, "_sat"}, {31'b0, bus.int_sat}, {31'b0, exp_sat[i-2]});
      end
      if (i < n) begin
        bus.strobe_in = 1'b1;
        bus.ang_in    = ang;
        bus.kp_sh     = kp;
        bus.ki_sh     = ki;
        bus.hold      = hld;
        bus.int_clear = clr;
      end else begin
        bus.strobe_in = 1'b0;
        bus.hold      = 1'b0;
        bus.int_clear = 1'b0;
      end
      tick();
    end
    check({tag, "_idle"}, {31'b0, bus.strobe_out}, 32'd0);
  endtask

  task automatic set_exp1(input int c, input logic s);
    exp_ctl[0] = c;
    exp_sat[0] = s;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.ang_in = '0;
    bus.strobe_in = 1'b0;
    bus.kp_sh = '0;
    bus.ki_sh = '0;
    bus.hold = 1'b0;
    bus.int_clear = 1'b0;
    tick();
    do_reset();
    check("rst_ctl", {14'b0, bus.ctl_out}, 32'd0);
    check("rst_stb", {31'b0, bus.strobe_out}, 32'd0);
    check("rst_sat", {31'b0, bus.int_sat}, 32'd0);

    // prop = 2^17, inc = 2^13 per sample; ctl = (acc + prop) >> 6.
    exp_ctl[0] = 2176; exp_ctl[1] = 2304; exp_ctl[2] = 2432; exp_ctl[3] = 2560;
    for (int i = 0; i < 4; i++) exp_sat[i] = 1'b0;
    run_burst("t1", 4, 17'h01000, 4'd2, 4'd6, 1'b0, 1'b0);

    // Hold with zero error: acc 32768 -> 512 on every output.
    for (int i = 0; i < 3; i++) begin
      exp_ctl[i] = 512;
      exp_sat[i] = 1'b0;
    end
    run_burst("t4_hold", 3, 17'h00000, 4'd2, 4'd6, 1'b1, 1'b0);
    // Hold with nonzero error: only prop contributes, acc stays 32768.
    set_exp1(2560, 1'b0);
    run_burst("t4_hold_p", 1, 17'h01000, 4'd2, 4'd6, 1'b1, 1'b0);
    set_exp1(512, 1'b0);
    run_burst("t4_after", 1, 17'h00000, 4'd2, 4'd6, 1'b0, 1'b0);

    // Clear with strobe and hold: acc = 0, ctl = prop >> 6.
    set_exp1(2048, 1'b0);
    run_burst("t5_clr", 1, 17'h01000, 4'd2, 4'd6, 1'b1, 1'b1);
    set_exp1(0, 1'b0);
    run_burst("t5_acc0", 1, 17'h00000, 4'd2, 4'd6, 1'b0, 1'b0);

    // Clear without strobe.
    set_exp1(2176, 1'b0);
    run_burst("clr_pre", 1, 17'h01000, 4'd2, 4'd6, 1'b0, 1'b0);
    bus.int_clear = 1'b1;
    tick();
    bus.int_clear = 1'b0;
    set_exp1(0, 1'b0);
    run_burst("clr_solo", 1, 17'h00000, 4'd2, 4'd6, 1'b0, 1'b0);

    // Positive saturation.
    do_reset();
    set_exp1(32'h1FFFF, 1'b1);
    run_burst("t2_a", 1, 17'h0FFFF, 4'd0, 4'd0, 1'b0, 1'b0);
    set_exp1(32'h1FFFF, 1'b1);
    run_burst("t2_b", 1, 17'h0FFFF, 4'd0, 4'd0, 1'b0, 1'b0);
    set_exp1(32'h1FFFF, 1'b0);
    run_burst("t2_acc", 1, 17'h00000, 4'd0, 4'd0, 1'b0, 1'b0);

    // Negative full scale: acc lands exactly on min (no clamp), sum clamps.
    do_reset();
    set_exp1(32'h20000, 1'b1);
    run_burst("t3_a", 1, 17'h10000, 4'd0, 4'd0, 1'b0, 1'b0);
    set_exp1(32'h20000, 1'b0);
    run_burst("t3_acc", 1, 17'h00000, 4'd0, 4'd0, 1'b0, 1'b0);

    // Reset one cycle after a strobe drops the in-flight sample.
    bus.strobe_in = 1'b1;
    bus.ang_in    = 17'h01000;
    bus.kp_sh     = 4'd2;
    bus.ki_sh     = 4'd6;
    tick();
    bus.strobe_in = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_stb", {31'b0, bus.strobe_out}, 32'd0);
    check("t6_ctl", {14'b0, bus.ctl_out}, 32'd0);
    check("t6_sat", {31'b0, bus.int_sat}, 32'd0);
    tick();
    check("t6_stb2", {31'b0, bus.strobe_out}, 32'd0);
    set_exp1(2176, 1'b0);
    run_burst("t6_next", 1, 17'h01000, 4'd2, 4'd6, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
